exhaustive_test_monitor: RTL and testbench
==========================================

Name: exhaustive_test_monitor

Overview:
Receiving end of the exhaustive adder-test interface: consumes the stream of applied vectors {a, b, cin} and per-vector error flags produced by the exhaustive tester, plus its done strobe. Counts vectors and failures, captures the first failing vector, checks that the sweep covered every combination in order, and issues a final pass/fail verdict. Sits between the tester and board-level LEDs / seven-segment display logic.

Parameters:
WIDTH, 4, operand width of a and b
CNT_W, 10, width of vector and error counters (saturating)
EXPECTED_VECTORS, 512, vectors required for a complete sweep (2^(2*WIDTH+1))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
vec_valid  input  1  a/b/cin/error describe one applied vector this cycle
a  input  WIDTH  operand a of current vector
b  input  WIDTH  operand b of current vector
cin  input  1  carry-in of current vector
error  input  1  current vector failed its check
done  input  1  tester finished; single-cycle or level strobe
clear  input  1  return to IDLE from REPORT
vec_count  output  CNT_W  vectors accepted
err_count  output  CNT_W  failing vectors accepted
fail_valid  output  1  first-fail capture registers hold data
first_fail_a  output  WIDTH  a of first failing vector
first_fail_b  output  WIDTH  b of first failing vector
first_fail_cin  output  1  cin of first failing vector
order_err  output  1  sticky: vector arrived out of sweep order
finished  output  1  in REPORT state
pass  output  1  verdict, valid when finished=1

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; all outputs 0; expected index 0. Reset mid-run discards everything, no partial verdict.
- Clock/reset: one clock, clk; reset is synchronous and active-high, port rst.
- States: IDLE, RUN, REPORT. All outputs registered; counters update the edge after the sampled vec_valid.
- IDLE: vec_valid=1 -> accept vector, go RUN. done=1 with no vec_valid -> REPORT (pass=0).
- RUN: each vec_valid increments vec_count; error=1 also increments err_count. Both saturate at 2^CNT_W-1, no wrap.
- First accepted vector with error=1 loads first_fail_* and sets fail_valid; later failures never overwrite.
- Sweep order: index {cin,b,a} (a fastest, then b, then cin), starting at 0, incrementing by 1 per accepted vector. Mismatch sets order_err (sticky); expected index resynchronises to received index + 1. Index wraps modulo 2^(2*WIDTH+1).
- done=1 in RUN -> REPORT next edge. done and vec_valid in the same cycle: vector accepted first, verdict includes it.
- Verdict, registered on entry to REPORT: pass = (err_count==0) && (vec_count==EXPECTED_VECTORS) && !order_err, using post-update values.
- REPORT: outputs frozen; vec_valid and done ignored; clear=1 -> IDLE with all counters, captures, and flags zeroed. clear is ignored outside REPORT. rst has priority over clear.

Optional Feature:
EXH_MON_ORDER_CHECK_EN
- Defined: sweep-order checker present as described; order_err participates in pass.
- Undefined: no expected-index logic; order_err tied 0; pass = (err_count==0) && (vec_count==EXPECTED_VECTORS).

Decomposition:
- Package exh_mon_pkg: state enum (IDLE, RUN, REPORT), default WIDTH/CNT_W, EXPECTED_VECTORS derivation constant.
- One sub-module: sat_counter (parameter W; inc, clr, synchronous rst; saturates at all-ones), instantiated for vec_count and err_count.

Test Plan:
- Clean sweep: 512 in-order vectors with error=0, then done -> finished=1, pass=1, vec_count=512, err_count=0, order_err=0.
- Failures: error=1 at (a=5,b=3,cin=0) and (a=9,b=14,cin=1) -> err_count=2, first_fail=5/3/0, fail_valid=1, pass=0.
- Short sweep: 511 vectors (omit last), then done -> vec_count=511, pass=0, order_err=0.
- Order fault: skip a=7,b=0,cin=0 (511 vectors) -> order_err=1 on the next vector; later vectors produce no further fault; pass=0. With macro undefined -> order_err=0.
- Boundary: done in the same cycle as vector 512 -> vec_count=512, pass=1. vec_valid pulses in REPORT leave counts unchanged. clear -> all outputs 0 and IDLE.
- Reset mid-run: rst after 100 vectors, then a full clean sweep -> pass=1, vec_count=512.

Source files
------------

// File: rtl/exh_mon_pkg.sv
// Shared types and default sizing for the exhaustive adder-test monitor.
`timescale 1ns/1ps
package exh_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 10;

  // A full sweep covers every {cin, b, a} combination exactly once.
  function automatic int exp_vectors(input int width);
    return 1 << (2 * width + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; next value exposed so callers can act on post-update counts.
// Updates one edge after i_inc; i_clr wins over i_inc, rst wins over both.
`timescale 1ns/1ps
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_nxt
);

  always_comb begin
    o_nxt = o_q;
    if (i_clr) begin
      o_nxt = '0;
    end else if (i_inc && (o_q != '1)) begin
      o_nxt = o_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else begin
      o_q <= o_nxt;
    end
  end

endmodule

// File: rtl/exhaustive_test_monitor.sv
// Monitor for the exhaustive adder tester: counts vectors/failures, captures first failure, registers a verdict.
// All outputs registered, one edge after the sampled inputs; no backpressure. Sweep-order checker: EXH_MON_ORDER_CHECK_EN.
`timescale 1ns/1ps
module exhaustive_test_monitor
  import exh_mon_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int EXPECTED_VECTORS = exp_vectors(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vec_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             error,
  input  logic             done,
  input  logic             clear,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b,
  output logic             first_fail_cin,
  output logic             order_err,
  output logic             finished,
  output logic             pass
);

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXPECTED_VECTORS);

  state_t             r_state;
  logic               r_fail_valid;
  logic [WIDTH-1:0]   r_ff_a;
  logic [WIDTH-1:0]   r_ff_b;
  logic               r_ff_cin;
  logic               r_finished;
  logic               r_pass;

  logic               w_accept;
  logic               w_clear;
  logic               w_order_nxt;
  logic               w_verdict;
  logic [CNT_W-1:0]   w_vec_nxt;
  logic [CNT_W-1:0]   w_err_nxt;

  assign w_accept = vec_valid && (r_state != ST_REPORT);
  assign w_clear  = clear && (r_state == ST_REPORT);

  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_accept),
    .i_clr (w_clear),
    .o_q   (vec_count),
    .o_nxt (w_vec_nxt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_accept && error),
    .i_clr (w_clear),
    .o_q   (err_count),
    .o_nxt (w_err_nxt)
  );

`ifdef EXH_MON_ORDER_CHECK_EN
  localparam int IDX_W = 2 * WIDTH + 1;

  logic [IDX_W-1:0] r_exp_idx;
  logic             r_order_err;
  logic [IDX_W-1:0] w_idx;

  assign w_idx       = {cin, b, a};
  assign w_order_nxt = r_order_err || (w_accept && (w_idx != r_exp_idx));

  // After a mismatch, track the received sequence so one gap flags only once.
  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_exp_idx   <= '0;
      r_order_err <= 1'b0;
    end else if (w_accept) begin
      r_exp_idx   <= w_idx + 1'b1;
      r_order_err <= w_order_nxt;
    end
  end

  assign order_err = r_order_err;
`else
  assign w_order_nxt = 1'b0;
  assign order_err   = 1'b0;
`endif

  // Verdict uses post-update counts so a vector arriving with done is included.
  assign w_verdict = (w_err_nxt == '0) && (w_vec_nxt == EXP_CNT) && !w_order_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fail_valid <= 1'b0;
      r_ff_a       <= '0;
      r_ff_b       <= '0;
      r_ff_cin     <= 1'b0;
      r_finished   <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          if (w_accept && error && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_ff_a       <= a;
            r_ff_b       <= b;
            r_ff_cin     <= cin;
          end
          if (done) begin
            r_state    <= ST_REPORT;
            r_finished <= 1'b1;
            r_pass     <= w_verdict;
          end else if (vec_valid) begin
            r_state <= ST_RUN;
          end
        end
        ST_REPORT: begin
          if (clear) begin
            r_state      <= ST_IDLE;
            r_fail_valid <= 1'b0;
            r_ff_a       <= '0;
            r_ff_b       <= '0;
            r_ff_cin     <= 1'b0;
            r_finished   <= 1'b0;
            r_pass       <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fail_valid     = r_fail_valid;
  assign first_fail_a   = r_ff_a;
  assign first_fail_b   = r_ff_b;
  assign first_fail_cin = r_ff_cin;
  assign finished       = r_finished;
  assign pass           = r_pass;

endmodule

// File: tb/tb_exhaustive_test_monitor.sv
// Directed bench for exhaustive_test_monitor; order_err expectation follows EXH_MON_ORDER_CHECK_EN.
`timescale 1ns/1ps
module tb_exhaustive_test_monitor;

  logic       clk;
  logic       rst;
  logic       vec_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       error;
  logic       done;
  logic       clear;
  logic [9:0] vec_count;
  logic [9:0] err_count;
  logic       fail_valid;
  logic [3:0] first_fail_a;
  logic [3:0] first_fail_b;
  logic       first_fail_cin;
  logic       order_err;
  logic       finished;
  logic       pass;

  int n_checks = 0;
  int n_errors = 0;

`ifdef EXH_MON_ORDER_CHECK_EN
  localparam int EXP_ORD = 1;
`else
  localparam int EXP_ORD = 0;
`endif

  exhaustive_test_monitor dut (
    .clk            (clk),
    .rst            (rst),
    .vec_valid      (vec_valid),
    .a              (a),
    .b              (b),
    .cin            (cin),
    .error          (error),
    .done           (done),
    .clear          (clear),
    .vec_count      (vec_count),
    .err_count      (err_count),
    .fail_valid     (fail_valid),
    .first_fail_a   (first_fail_a),
    .first_fail_b   (first_fail_b),
    .first_fail_cin (first_fail_cin),
    .order_err      (order_err),
    .finished       (finished),
    .pass           (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic e, input logic d);
    logic [8:0] v;
    v         = idx[8:0];
    {cin,b,a} = v;
    error     = e;
    done      = d;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    error     = 1'b0;
    done      = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vec"},  int'(vec_count), 0);
    chk({tag, ".err"},  int'(err_count), 0);
    chk({tag, ".fv"},   int'(fail_valid), 0);
    chk({tag, ".ffa"},  int'(first_fail_a), 0);
    chk({tag, ".ffb"},  int'(first_fail_b), 0);
    chk({tag, ".ffc"},  int'(first_fail_cin), 0);
    chk({tag, ".ord"},  int'(order_err), 0);
    chk({tag, ".fin"},  int'(finished), 0);
    chk({tag, ".pass"}, int'(pass), 0);
  endtask

  // Sends indices 0..last except skip; e1/e2 mark failing indices.
  task automatic sweep(input int last, input int skip, input int e1, input int e2);
    for (int i = 0; i <= last; i++) begin
      if (i != skip) send(i, (i == e1) || (i == e2), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; vec_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    error = 1'b0; done = 1'b0; clear = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Clean sweep
    sweep(511, -1, -1, -1);
    chk("clean.fin_pre", int'(finished), 0);
    pulse_done();
    chk("clean.fin",  int'(finished), 1);
    chk("clean.pass", int'(pass), 1);
    chk("clean.vec",  int'(vec_count), 512);
    chk("clean.err",  int'(err_count), 0);
    chk("clean.ord",  int'(order_err), 0);
    chk("clean.fv",   int'(fail_valid), 0);

    // Activity in REPORT is ignored
    send(3, 1'b1, 1'b0);
    send(4, 1'b1, 1'b1);
    chk("rep.vec",  int'(vec_count), 512);
    chk("rep.err",  int'(err_count), 0);
    chk("rep.pass", int'(pass), 1);
    chk("rep.fv",   int'(fail_valid), 0);
    do_clear();
    chk_all_zero("clear1");

    // clear outside REPORT has no effect
    send(0, 1'b0, 1'b0);
    do_clear();
    chk("clrrun.vec", int'(vec_count), 1);
    rst = 1'b1; tick(); rst = 1'b0;

    // Two failures: a=5,b=3,cin=0 -> 53 ; a=9,b=14,cin=1 -> 489
    sweep(511, -1, 53, 489);
    pulse_done();
    chk("fail.err",  int'(err_count), 2);
    chk("fail.vec",  int'(vec_count), 512);
    chk("fail.fv",   int'(fail_valid), 1);
    chk("fail.ffa",  int'(first_fail_a), 5);
    chk("fail.ffb",  int'(first_fail_b), 3);
    chk("fail.ffc",  int'(first_fail_cin), 0);
    chk("fail.pass", int'(pass), 0);
    chk("fail.fin",  int'(finished), 1);
    do_clear();
    chk_all_zero("clear2");

    // Short sweep (last vector omitted)
    sweep(510, -1, -1, -1);
    pulse_done();
    chk("short.vec",  int'(vec_count), 511);
    chk("short.pass", int'(pass), 0);
    chk("short.ord",  int'(order_err), 0);
    do_clear();

    // Order fault: skip a=7,b=0,cin=0 (index 7)
    sweep(6, -1, -1, -1);
    chk("ord.before", int'(order_err), 0);
    send(8, 1'b0, 1'b0);
    chk("ord.hit", int'(order_err), EXP_ORD);
    for (int i = 9; i <= 511; i++) send(i, 1'b0, 1'b0);
    pulse_done();
    chk("ord.final", int'(order_err), EXP_ORD);
    chk("ord.vec",   int'(vec_count), 511);
    chk("ord.pass",  int'(pass), 0);
    do_clear();

    // done together with the 512th vector
    sweep(510, -1, -1, -1);
    send(511, 1'b0, 1'b1);
    chk("same.fin",  int'(finished), 1);
    chk("same.vec",  int'(vec_count), 512);
    chk("same.pass", int'(pass), 1);
    do_clear();

    // done in IDLE with no vectors
    pulse_done();
    chk("idle.fin",  int'(finished), 1);
    chk("idle.pass", int'(pass), 0);
    chk("idle.vec",  int'(vec_count), 0);
    do_clear();

    // Reset mid-run, then a clean sweep
    sweep(99, -1, -1, -1);
    chk("mid.vec100", int'(vec_count), 100);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid.vec0", int'(vec_count), 0);
    chk("mid.fin0", int'(finished), 0);
    sweep(511, -1, -1, -1);
    pulse_done();
    chk("mid.pass", int'(pass), 1);
    chk("mid.vec",  int'(vec_count), 512);
    do_clear();

    // Saturation at 1023
    for (int i = 0; i < 1100; i++) send(i % 512, 1'b1, 1'b0);
    chk("sat.vec", int'(vec_count), 1023);
    chk("sat.err", int'(err_count), 1023);
    pulse_done();
    chk("sat.pass", int'(pass), 0);
    chk("sat.ffa",  int'(first_fail_a), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
